// File: rtl/hazard_flush_controller.sv
// Pipeline hazard / flush / forwarding controller for the 5-stage core.
// After reset, fetch and decode are held stalled and decode flushed for
// RST_HOLD_CYCLES cycles, then the control decode runs purely combinationally.
// Optional build macro HAZARD_PERF_CNT_EN enables the redirect / load-use
// stall performance counters; when undefined, both counter ports read 0.
module hazard_flush_controller #(
  parameter int unsigned RST_HOLD_CYCLES = 2,
  parameter int unsigned REG_ADDR_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_dec,
  input  logic [REG_ADDR_W-1:0] rs2_dec,
  input  logic [REG_ADDR_W-1:0] rs1_exe,
  input  logic [REG_ADDR_W-1:0] rs2_exe,
  input  logic [REG_ADDR_W-1:0] rd_exe,
  input  logic                  result_src_exe_b0,
  input  logic                  pc_src_exe,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  reg_write_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  reg_write_wb,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  flush_decode,
  output logic                  flush_exe,
  output logic [1:0]            forward_a_exe,
  output logic [1:0]            forward_b_exe,
  output logic [1:0]            ctrl_state,
  output logic [31:0]           perf_redirect_cnt,
  output logic [31:0]           perf_stall_cnt
);

  localparam int unsigned CntW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'(RST_HOLD_CYCLES);

  typedef enum logic [1:0] {
    StHold = 2'b00,
    StRun  = 2'b01
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic redirect;
  logic lw_stall;
  logic is_run;

  // Forward select: memory stage beats writeback, x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  wr_mem,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  wr_wb,
    input logic [REG_ADDR_W-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_mem && (rd_m != '0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_wb && (rd_w != '0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // State register and hold counter; reset reloads the full hold count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHold;
      cnt_q   <= HoldLoad;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: leave HOLD on the edge where the count reaches zero, so HOLD
  // lasts exactly RST_HOLD_CYCLES cycles after release (minimum one cycle,
  // since the state register can only change at an edge).
  always_comb begin
    state_d = StHold;
    cnt_d   = cnt_q;
    unique case (state_q)
      StHold: begin
        cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
        state_d = (cnt_q <= CntW'(1)) ? StRun : StHold;
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StHold;
        cnt_d   = HoldLoad;
      end
    endcase
  end

  // Hazard detection; X/Z on pc_src_exe counts as not-taken.
  always_comb begin
    redirect = (pc_src_exe === 1'b1);
    lw_stall = result_src_exe_b0 && (rd_exe != '0) &&
               ((rd_exe == rs1_dec) || (rd_exe == rs2_dec));
    is_run   = (state_q == StRun);
  end

  // Control outputs: HOLD (and any illegal state) drives the reset values.
  always_comb begin
    stall_fetch   = 1'b1;
    stall_decode  = 1'b1;
    flush_decode  = 1'b1;
    flush_exe     = 1'b1;
    forward_a_exe = 2'b00;
    forward_b_exe = 2'b00;
    if (is_run) begin
      // Redirect wins over a load-use stall: the stalled instruction is flushed anyway.
      stall_fetch   = lw_stall && !redirect;
      stall_decode  = lw_stall && !redirect;
      flush_decode  = redirect;
      flush_exe     = redirect || lw_stall;
      forward_a_exe = fwd_sel(rs1_exe, reg_write_mem, rd_mem, reg_write_wb, rd_wb);
      forward_b_exe = fwd_sel(rs2_exe, reg_write_mem, rd_mem, reg_write_wb, rd_wb);
    end
  end

  assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, stall_cnt_q;

  // Saturating event counters, counted only in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (is_run && redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
      if (is_run && lw_stall && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_redirect_cnt = redirect_cnt_q;
  assign perf_stall_cnt    = stall_cnt_q;
`else
  assign perf_redirect_cnt = 32'd0;
  assign perf_stall_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_flush_controller.sv
module tb_hazard_flush_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_dec, rs2_dec, rs1_exe, rs2_exe, rd_exe, rd_mem, rd_wb;
  logic       result_src_exe_b0, pc_src_exe, reg_write_mem, reg_write_wb;
  logic       stall_fetch, stall_decode, flush_decode, flush_exe;
  logic [1:0] forward_a_exe, forward_b_exe, ctrl_state;
  logic [31:0] perf_redirect_cnt, perf_stall_cnt;

  int total = 0;
  int bad   = 0;

  // {stall_fetch, stall_decode, flush_decode, flush_exe}
  logic [3:0] ctl;
  assign ctl = {stall_fetch, stall_decode, flush_decode, flush_exe};

  always #5 clk = ~clk;

  hazard_flush_controller #(
    .RST_HOLD_CYCLES(2),
    .REG_ADDR_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rs1_dec(rs1_dec),
    .rs2_dec(rs2_dec),
    .rs1_exe(rs1_exe),
    .rs2_exe(rs2_exe),
    .rd_exe(rd_exe),
    .result_src_exe_b0(result_src_exe_b0),
    .pc_src_exe(pc_src_exe),
    .rd_mem(rd_mem),
    .reg_write_mem(reg_write_mem),
    .rd_wb(rd_wb),
    .reg_write_wb(reg_write_wb),
    .stall_fetch(stall_fetch),
    .stall_decode(stall_decode),
    .flush_decode(flush_decode),
    .flush_exe(flush_exe),
    .forward_a_exe(forward_a_exe),
    .forward_b_exe(forward_b_exe),
    .ctrl_state(ctrl_state),
    .perf_redirect_cnt(perf_redirect_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  task automatic drive_idle();
    rs1_dec = 0; rs2_dec = 0; rs1_exe = 0; rs2_exe = 0; rd_exe = 0;
    rd_mem = 0; rd_wb = 0; result_src_exe_b0 = 0; pc_src_exe = 0;
    reg_write_mem = 0; reg_write_wb = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert rst for two edges, release, and return the number of HOLD cycles seen.
  task automatic do_reset(output int hold_cycles);
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    hold_cycles = 0;
    while (ctrl_state == 2'b00 && hold_cycles < 10) begin
      hold_cycles++;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    int n;
    drive_idle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    total++;
    if (ctl !== 4'b1111 || ctrl_state !== 2'b00) begin
      bad++;
      $display("FAIL reset_values: ctl=%b state=%b want ctl=1111 state=00", ctl, ctrl_state);
    end
    // Forward and redirect requests must be ignored while holding.
    rs1_exe = 3; rd_mem = 3; reg_write_mem = 1; pc_src_exe = 1;
    rst = 1'b0;
    #1;
    total++;
    if (ctl !== 4'b1111 || forward_a_exe !== 2'b00) begin
      bad++;
      $display("FAIL hold_masks: ctl=%b fwd_a=%b want ctl=1111 fwd_a=00", ctl, forward_a_exe);
    end
    drive_idle();
    n = 0;
    while (ctrl_state == 2'b00 && n < 10) begin
      total++;
      if (ctl !== 4'b1111) begin
        bad++;
        $display("FAIL hold_ctl: ctl=%b want 1111", ctl);
      end
      n++;
      next_cycle();
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL hold_len: got %0d cycles want 2", n);
    end
    total++;
    if (ctrl_state !== 2'b01 || ctl !== 4'b0000) begin
      bad++;
      $display("FAIL run_entry: state=%b ctl=%b want state=01 ctl=0000", ctrl_state, ctl);
    end
  endtask

  task automatic test_load_use();
    drive_idle();
    result_src_exe_b0 = 1; rd_exe = 5; rs2_dec = 5;
    #1;
    total++;
    if (ctl !== 4'b1101) begin
      bad++;
      $display("FAIL lu_rs2: ctl=%b want 1101", ctl);
    end
    rs2_dec = 0; rs1_dec = 5;
    #1;
    total++;
    if (ctl !== 4'b1101) begin
      bad++;
      $display("FAIL lu_rs1: ctl=%b want 1101", ctl);
    end
    rd_exe = 0; rs1_dec = 0; rs2_dec = 0;
    #1;
    total++;
    if (ctl !== 4'b0000) begin
      bad++;
      $display("FAIL lu_x0: ctl=%b want 0000", ctl);
    end
    rd_exe = 5; rs1_dec = 6; rs2_dec = 4;
    #1;
    total++;
    if (ctl !== 4'b0000) begin
      bad++;
      $display("FAIL lu_nomatch: ctl=%b want 0000", ctl);
    end
    result_src_exe_b0 = 0; rs2_dec = 5;
    #1;
    total++;
    if (ctl !== 4'b0000) begin
      bad++;
      $display("FAIL lu_notload: ctl=%b want 0000", ctl);
    end
  endtask

  task automatic test_redirect();
    drive_idle();
    pc_src_exe = 1;
    #1;
    total++;
    if (ctl !== 4'b0011) begin
      bad++;
      $display("FAIL redir_only: ctl=%b want 0011", ctl);
    end
    result_src_exe_b0 = 1; rd_exe = 5; rs2_dec = 5;
    #1;
    total++;
    if (ctl !== 4'b0011) begin
      bad++;
      $display("FAIL redir_wins: ctl=%b want 0011", ctl);
    end
    pc_src_exe = 1'bx;
    #1;
    total++;
    if (ctl !== 4'b1101) begin
      bad++;
      $display("FAIL redir_x: ctl=%b want 1101", ctl);
    end
  endtask

  task automatic test_forwarding();
    drive_idle();
    rs1_exe = 7; reg_write_mem = 1; rd_mem = 7; reg_write_wb = 1; rd_wb = 7;
    #1;
    total++;
    if (forward_a_exe !== 2'b10) begin
      bad++;
      $display("FAIL fwd_a_mem: got %b want 10", forward_a_exe);
    end
    reg_write_mem = 0;
    #1;
    total++;
    if (forward_a_exe !== 2'b01) begin
      bad++;
      $display("FAIL fwd_a_wb: got %b want 01", forward_a_exe);
    end
    rd_wb = 0;
    #1;
    total++;
    if (forward_a_exe !== 2'b00) begin
      bad++;
      $display("FAIL fwd_a_none: got %b want 00", forward_a_exe);
    end
    drive_idle();
    rs2_exe = 9; rs1_exe = 3; reg_write_mem = 1; rd_mem = 3; reg_write_wb = 1; rd_wb = 9;
    #1;
    total++;
    if (forward_a_exe !== 2'b10 || forward_b_exe !== 2'b01) begin
      bad++;
      $display("FAIL fwd_ab: a=%b b=%b want a=10 b=01", forward_a_exe, forward_b_exe);
    end
    drive_idle();
    reg_write_mem = 1; reg_write_wb = 1;
    #1;
    total++;
    if (forward_a_exe !== 2'b00 || forward_b_exe !== 2'b00) begin
      bad++;
      $display("FAIL fwd_x0: a=%b b=%b want 00 00", forward_a_exe, forward_b_exe);
    end
  endtask

  task automatic test_reset_mid_stall();
    int n;
    drive_idle();
    result_src_exe_b0 = 1; rd_exe = 5; rs1_dec = 5;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    total++;
    if (ctl !== 4'b1111 || ctrl_state !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset: ctl=%b state=%b want ctl=1111 state=00", ctl, ctrl_state);
    end
    n = 0;
    while (ctrl_state == 2'b00 && n < 10) begin
      n++;
      next_cycle();
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL mid_reload: got %0d hold cycles want 2", n);
    end
    total++;
    if (ctl !== 4'b1101) begin
      bad++;
      $display("FAIL mid_resume: ctl=%b want 1101", ctl);
    end
  endtask

  task automatic test_perf();
    int n;
    logic [2:0] vec [7];
    logic [31:0] exp_r, exp_s;
    // {pc_src, load, match}
    vec[0] = 3'b100; vec[1] = 3'b011; vec[2] = 3'b111; vec[3] = 3'b011;
    vec[4] = 3'b100; vec[5] = 3'b011; vec[6] = 3'b000;
    drive_idle();
    do_reset(n);
    total++;
    if (perf_redirect_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_clear: r=%0d s=%0d want 0 0", perf_redirect_cnt, perf_stall_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      pc_src_exe = vec[i][2];
      result_src_exe_b0 = vec[i][1];
      rd_exe = 5;
      rs2_dec = vec[i][0] ? 5'd5 : 5'd6;
      next_cycle();
    end
    drive_idle();
`ifdef HAZARD_PERF_CNT_EN
    exp_r = 32'd3;
    exp_s = 32'd3;
`else
    exp_r = 32'd0;
    exp_s = 32'd0;
`endif
    total++;
    if (perf_redirect_cnt !== exp_r || perf_stall_cnt !== exp_s) begin
      bad++;
      $display("FAIL perf_counts: r=%0d s=%0d want r=%0d s=%0d",
               perf_redirect_cnt, perf_stall_cnt, exp_r, exp_s);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_forwarding();
    test_reset_mid_stall();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
